// File: rtl/vout_sampler.sv
// Composite video sampler: maps raw PPU DAC lines to a millivolt level, box-averages
// it over one PCLK-aligned pixel window and queues per-pixel samples in a small FIFO.
module vout_sampler #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic [10:0] RawVOut,
    input  logic        PCLK,
    output logic [10:0] level,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        resync_err,
    output logic        overflow
);

    localparam int unsigned LVL_W = 11;
    localparam int unsigned LOG2W = $clog2(WINDOW);
    localparam int unsigned ACC_W = LVL_W + LOG2W;
    localparam int unsigned PH_W  = LOG2W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             sync_seen;
        logic [LVL_W-1:0] avg;
    } sample_t;

    // Sample stage
    logic [LVL_W-1:0] level_q, level_d;
    logic             sync_q, sync_d;
    logic             start_q, start_d;
    logic             pclk_prev_q, pclk_prev_d;

    // Window stage
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             active_q, active_d;
    logic             sync_any_q, sync_any_d;
    logic             resync_q, resync_d;
    logic             push_vld_q, push_vld_d;
    sample_t          push_data_q, push_data_d;

    // FIFO
    sample_t          mem_q [DEPTH];
    sample_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       hi_idx;
    logic             any_bit;
    logic [LVL_W-1:0] base_lvl;
    logic [ACC_W-1:0] sum_c;
    logic             sync_c;
    logic             pop_c;
    logic             full_c;
    logic             push_ok_c;

    // Highest set DAC line picks the level; TINT attenuates all but sync-only.
    always_comb begin
        hi_idx  = 4'd0;
        any_bit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (RawVOut[i]) begin
                hi_idx  = 4'(i);
                any_bit = 1'b1;
            end
        end
        case (hi_idx)
            4'd0:    base_lvl = 11'd48;
            4'd1:    base_lvl = 11'd148;
            4'd2:    base_lvl = 11'd228;
            4'd3:    base_lvl = 11'd312;
            4'd4:    base_lvl = 11'd524;
            4'd5:    base_lvl = 11'd552;
            4'd6:    base_lvl = 11'd616;
            4'd7:    base_lvl = 11'd840;
            4'd8:    base_lvl = 11'd880;
            4'd9:    base_lvl = 11'd1100;
            default: base_lvl = 11'd0;
        endcase
        if (!any_bit) begin
            base_lvl = 11'd0;
        end
        level_d     = (RawVOut[10] && any_bit && (hi_idx != 4'd0))
                      ? base_lvl - (base_lvl >> 2) : base_lvl;
        sync_d      = any_bit && (hi_idx == 4'd0);
        start_d     = PCLK && !pclk_prev_q;
        pclk_prev_d = PCLK;
    end

    // Window accumulation; a start mid-window throws away the partial sum.
    always_comb begin
        acc_d       = acc_q;
        phase_d     = phase_q;
        active_d    = active_q;
        sync_any_d  = sync_any_q;
        resync_d    = 1'b0;
        push_vld_d  = 1'b0;
        push_data_d = '0;

        sum_c  = (start_q || phase_q == '0) ? ACC_W'(level_q) : acc_q + ACC_W'(level_q);
        sync_c = (start_q || phase_q == '0) ? sync_q : (sync_any_q | sync_q);

        if (start_q) begin
            active_d = 1'b1;
            resync_d = (phase_q != '0);
        end

        if (start_q || active_q) begin
            if (!start_q && phase_q == PH_W'(WINDOW - 1)) begin
                push_vld_d            = 1'b1;
                push_data_d.sync_seen = sync_c;
                push_data_d.avg       = LVL_W'(sum_c >> LOG2W);
                phase_d               = '0;
            end else begin
                acc_d      = sum_c;
                sync_any_d = sync_c;
                phase_d    = start_q ? PH_W'(1) : phase_q + PH_W'(1);
            end
        end
    end

    // FIFO: a push into a full FIFO only lands if the head leaves this cycle.
    always_comb begin
        pop_c     = (count_q != '0) && sample_ready;
        full_c    = (count_q == CNT_W'(DEPTH));
        push_ok_c = push_vld_q && (!full_c || pop_c);

        mem_d = mem_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data_q;
        end
        wr_ptr_d = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push_vld_q && !push_ok_c);
    end

    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            level_q     <= '0;
            sync_q      <= 1'b0;
            start_q     <= 1'b0;
            pclk_prev_q <= 1'b0;
            acc_q       <= '0;
            phase_q     <= '0;
            active_q    <= 1'b0;
            sync_any_q  <= 1'b0;
            resync_q    <= 1'b0;
            push_vld_q  <= 1'b0;
            push_data_q <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            level_q     <= level_d;
            sync_q      <= sync_d;
            start_q     <= start_d;
            pclk_prev_q <= pclk_prev_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            active_q    <= active_d;
            sync_any_q  <= sync_any_d;
            resync_q    <= resync_d;
            push_vld_q  <= push_vld_d;
            push_data_q <= push_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign level        = level_q;
    assign resync_err   = resync_q;
    assign overflow     = ovf_q;
    assign sample_valid = (count_q != '0);
    assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_vout_sampler.sv
// Directed bench for vout_sampler: a queue-based window/FIFO model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_vout_sampler;

    localparam int WINDOW = 8;
    localparam int DEPTH  = 4;
    localparam int LEVELS [10] = '{48, 148, 228, 312, 524, 552, 616, 840, 880, 1100};

    logic        CLK = 1'b0;
    logic        n_RES;
    logic [10:0] RawVOut;
    logic        PCLK;
    logic [10:0] level;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        resync_err;
    logic        overflow;

    vout_sampler #(.WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .n_RES        (n_RES),
        .RawVOut      (RawVOut),
        .PCLK         (PCLK),
        .level        (level),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .resync_err   (resync_err),
        .overflow     (overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state
    int   exp_fifo [$];
    int   win_lvl  [$];
    bit   win_sync [$];
    int   prev_level;
    bit   prev_sync;
    bit   prev_start;
    bit   pclk_prev;
    bit   started;
    bit   pend_vld;
    int   pend_data;
    bit   exp_resync;
    bit   exp_ovf;
    int   exp_level;

    logic [10:0] wraw [8] = '{11'h080, 11'h100, 11'h200, 11'h040,
                              11'h010 << 1, 11'h010, 11'h080, 11'h080};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int map_level(input logic [10:0] raw, output bit is_sync);
        int k;
        int l;
        k = -1;
        for (int i = 0; i < 10; i++) begin
            if (raw[i]) k = i;
        end
        is_sync = (k == 0);
        if (k < 0) return 0;
        l = LEVELS[k];
        if (raw[10] && k >= 1) l = l - l / 4;
        return l;
    endfunction

    task automatic model_edge(input logic [10:0] raw, input bit pclk, input bit rdy, input bit rst_n);
        bit pop;
        bit s;
        int sum;
        bit any;
        if (!rst_n) begin
            exp_fifo.delete();
            win_lvl.delete();
            win_sync.delete();
            prev_level = 0; prev_sync = 0; prev_start = 0; pclk_prev = 0;
            started = 0; pend_vld = 0; pend_data = 0;
            exp_resync = 0; exp_ovf = 0; exp_level = 0;
            return;
        end
        pop = (exp_fifo.size() > 0) && rdy;
        if (pend_vld && exp_fifo.size() == DEPTH && !pop) begin
            exp_ovf = 1;
        end else begin
            if (pop) void'(exp_fifo.pop_front());
            if (pend_vld) exp_fifo.push_back(pend_data);
        end

        exp_resync = 0;
        pend_vld   = 0;
        if (prev_start) begin
            if (win_lvl.size() != 0) exp_resync = 1;
            win_lvl.delete();
            win_sync.delete();
            started = 1;
        end
        if (started) begin
            win_lvl.push_back(prev_level);
            win_sync.push_back(prev_sync);
            if (win_lvl.size() == WINDOW) begin
                sum = 0;
                any = 0;
                foreach (win_lvl[i]) begin
                    sum += win_lvl[i];
                    any |= win_sync[i];
                end
                pend_vld  = 1;
                pend_data = (int'(any) << 11) | (sum / WINDOW);
                win_lvl.delete();
                win_sync.delete();
            end
        end

        exp_level  = map_level(raw, s);
        prev_level = exp_level;
        prev_sync  = s;
        prev_start = pclk && !pclk_prev;
        pclk_prev  = pclk;
    endtask

    // One master-clock cycle: drive, clock, advance model, compare on the falling edge.
    task automatic step(input logic [10:0] raw, input bit pclk, input bit rdy, input bit rst_n);
        n_RES        = rst_n;
        RawVOut      = raw;
        PCLK         = pclk;
        sample_ready = rdy;
        @(posedge CLK);
        model_edge(raw, pclk, rdy, rst_n);
        @(negedge CLK);
        chk("level", int'(level), exp_level);
        chk("resync_err", int'(resync_err), int'(exp_resync));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("sample_valid", int'(sample_valid), int'(exp_fifo.size() != 0));
        chk("sample_data", int'(sample_data), (exp_fifo.size() != 0) ? exp_fifo[0] : 0);
    endtask

    initial begin
        int nvalid;
        bit rdy;
        n_RES = 1'b0; RawVOut = '0; PCLK = 1'b0; sample_ready = 1'b1;

        // Reset
        for (int i = 0; i < 2; i++) begin
            step(11'h000, 1'b0, 1'b1, 1'b0);
            chk("rst_level", int'(level), 0);
            chk("rst_valid", int'(sample_valid), 0);
            chk("rst_data", int'(sample_data), 0);
            chk("rst_ovf", int'(overflow), 0);
            chk("rst_resync", int'(resync_err), 0);
        end

        // Steady luma1 H
        nvalid = 0;
        for (int s = 0; s < 32; s++) begin
            step(11'h080, (s % 8) < 4, 1'b1, 1'b1);
            if (s == 0) chk("steady_level", int'(level), 840);
            if (sample_valid) begin
                nvalid++;
                chk("steady_data", int'(sample_data), 12'h348);
            end
        end
        chk("steady_pushes", nvalid, 3);

        // Tint
        step(11'h600, 1'b0, 1'b1, 1'b1);
        chk("tint_l9", int'(level), 825);
        step(11'h401, 1'b0, 1'b1, 1'b1);
        chk("tint_sync", int'(level), 48);

        // Mixed sync + black window
        step(11'h000, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 10; s++) begin
            step((s < 4) ? 11'h001 : ((s < 8) ? 11'h008 : 11'h000), s < 4, 1'b0, 1'b1);
            if (s == 8) chk("mixed_pre_valid", int'(sample_valid), 0);
            if (s == 9) begin
                chk("mixed_valid", int'(sample_valid), 1);
                chk("mixed_data", int'(sample_data), 12'h8B4);
            end
        end

        // Early PCLK edge five samples into a window
        step(11'h000, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 15; s++) begin
            step(11'h080, (s < 3) || (s >= 5 && s < 8), 1'b0, 1'b1);
            if (s == 5) chk("early_resync_before", int'(resync_err), 0);
            if (s == 6) chk("early_resync", int'(resync_err), 1);
            if (s == 7) chk("early_resync_after", int'(resync_err), 0);
            if (s == 13) chk("early_no_push", int'(sample_valid), 0);
            if (s == 14) begin
                chk("early_push", int'(sample_valid), 1);
                chk("early_data", int'(sample_data), 12'h348);
            end
        end

        // Backpressure: six windows against a 4-deep FIFO, then drain
        step(11'h000, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 57; s++) begin
            step(wraw[s / 8], (s % 8) < 4, s >= 50, 1'b1);
            if (s == 33) chk("bp_valid_full", int'(sample_valid), 1);
            if (s == 40) chk("bp_ovf_before", int'(overflow), 0);
            if (s == 41) chk("bp_ovf", int'(overflow), 1);
            if (s == 49) begin
                chk("bp_head", int'(sample_data), 12'h348);
                chk("bp_ovf_sticky", int'(overflow), 1);
            end
            if (s == 50) chk("bp_pop1", int'(sample_data), 12'h370);
            if (s == 51) chk("bp_pop2", int'(sample_data), 12'h44C);
            if (s == 52) chk("bp_pop3", int'(sample_data), 12'h268);
            if (s == 53) chk("bp_empty", int'(sample_valid), 0);
        end

        // Full FIFO: push and pop on the same edge
        step(11'h000, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 52; s++) begin
            rdy = (s == 41) || (s >= 48);
            step(wraw[s / 8], (s % 8) < 4, rdy, 1'b1);
            if (s == 41) begin
                chk("pp_ovf", int'(overflow), 0);
                chk("pp_head", int'(sample_data), 12'h370);
            end
            if (s == 48) chk("pp_pop1", int'(sample_data), 12'h44C);
            if (s == 49) chk("pp_pop2", int'(sample_data), 12'h268);
            if (s == 50) chk("pp_tail", int'(sample_data), 12'h228);
            if (s == 51) chk("pp_next", int'(sample_data), 12'h20C);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vout_sampler.md
Name: vout_sampler

Overview:
- Downstream stage of the PPU video generator; consumes the 11-line raw composite output bus (RawVOut) once per master clock.
- Converts the active DAC lines into an 11-bit millivolt level, with emphasis attenuation applied.
- Box-averages the level over one pixel window aligned to PCLK, and queues the per-pixel samples in a small FIFO with a valid/ready handshake.
- Feeds the simulation frame-capture / composite-decode path.

Parameters:
- WINDOW, 8, master clocks per averaging window; power of two, 2..16.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- CLK  in  1  master clock; all state updates on the rising edge.
- n_RES  in  1  synchronous reset, active low.
- RawVOut  in  11  raw video lines from the video generator.
  - [0] sync; [1]/[4] burst L/H; [2]/[6] luma0 L/H; [3] black/luma1 L; [5] luma2 L; [7] luma1 H; [8] luma3 L; [9] luma2/3 H; [10] TINT.
- PCLK  in  1  pixel clock level; a rising edge marks a window start.
- level  out  11  registered instantaneous level, in mV.
- sample_data  out  12  FIFO head.
  - [10:0] window average, in mV.
  - [11] sync_seen.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer accepts the head this cycle.
- resync_err  out  1  one-cycle pulse when a partial window is discarded.
- overflow  out  1  sticky; set when a sample is dropped on a full FIFO.

Behaviour:
- Reset (n_RES=0 at a rising edge): level, accumulator, phase counter, sync_seen, FIFO pointers/count, pclk_d, resync_err and overflow all cleared to 0.
  - sample_data reads 0 while the FIFO is empty.
  - Reset mid-window discards the partial window; no push.
- Level map: the highest set bit index k in RawVOut[9:0] selects the level in mV:
  - k=0 → 48; k=1 → 148; k=2 → 228; k=3 → 312; k=4 → 524.
  - k=5 → 552; k=6 → 616; k=7 → 840; k=8 → 880; k=9 → 1100.
  - No bit set → 0.
- Tint: if RawVOut[10]=1 and k≥1, level = L − (L>>2) (truncating). Sync-only (k=0) and zero levels are unaffected.
- level is registered: RawVOut sampled at edge c appears on level after edge c.
- Edge detect: pclk_d <= PCLK each cycle. A sample at cycle c is a window start iff PCLK=1 and pclk_d=0 at c.
- Window accumulation: the accumulator is 11+log2(WINDOW) bits and cannot overflow. A phase counter tracks samples in the current window.
  - Start sample arriving with phase=0 (previous window just closed, or idle after reset): accumulator begins normally.
  - Start sample arriving with phase≠0: the partial window is discarded, resync_err pulses for one cycle, and the start sample begins the new window.
  - When phase reaches WINDOW−1 (WINDOW samples accumulated), the window closes:
    - average = sum >> log2(WINDOW);
    - sync_seen = 1 if any sample in the window had k=0 as its highest bit;
    - {sync_seen, average} is pushed; phase returns to 0.
  - With no further PCLK edge, windows free-run every WINDOW cycles.
  - After reset, accumulation waits for the first PCLK rising edge; samples before it are ignored.
- Latency: the last sample of a window is at RawVOut on edge c; its result is visible on sample_data, with sample_valid=1, after edge c+2 when the FIFO was empty.
- FIFO handshake:
  - Pop occurs when sample_valid && sample_ready at an edge.
  - sample_data is stable while sample_valid=1 and no pop occurs.
  - Push to a full FIFO with no pop: the sample is dropped and overflow is set (sticky until reset).
  - Push and pop in the same cycle while full: both accepted; count unchanged; no overflow.
  - Push and pop while empty is impossible, since valid=0.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Reset then steady luma: hold n_RES=0 for 2 cycles (all outputs 0), then RawVOut=0x080 (bit 7), PCLK edge every 8 cycles, sample_ready=1 → level=840; each sample_data=0x348 (840, sync_seen=0).
- Tint attenuation: RawVOut=0x600 (bits 10, 9) → level=825; RawVOut=0x401 (bits 10, 0) → level=48 (unattenuated).
- Mixed window with sync: 4 cycles 0x001, then 4 cycles 0x008 in one aligned window → sample_data = {1, 180} = 0x8B4.
- Early PCLK edge: edge 5 samples into a window → resync_err=1 for one cycle, no push for the partial window, and the next push occurs 8 samples after the early edge.
- Backpressure: sample_ready=0 for 6 windows with DEPTH=4 → sample_valid=1, count 4, overflow=1 after the 5th push. The head keeps the 1st window's value. Raise sample_ready: 4 pops in order, then valid=0.
- Full push+pop: FIFO full, ready=1 on the push cycle → no overflow, count stays 4, and the newest sample is retained at the tail.
